// File: rtl/telemetry_rx.sv
// 8N1 UART receiver with telemetry packet parser (AA 55 BH BL CH CL TH TL).
// Publishes three 12-bit values on pkt_rdy and flags framing, nibble and timeout faults on pkt_err.
module telemetry_rx #(
  parameter int BAUD_DIV     = 2604,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt_v,
  output logic [11:0] avg_curr,
  output logic [11:0] avg_torque,
  output logic        pkt_rdy,
  output logic        pkt_err,
  output logic [4:0]  dbg_state_o
);

  localparam int CW       = $clog2(BAUD_DIV);
  localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
  localparam int TW       = $clog2(TO_LIMIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;
  typedef enum logic [2:0] {P_HDR1, P_HDR2, P_BH, P_BL, P_CH, P_CL, P_TH, P_TL} pkt_state_e;

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e   uart_q, uart_d;
  pkt_state_e    pkt_q, pkt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sr_q, sr_d;
  logic          byte_rdy_q, byte_ok, frame_err, to_fire;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [11:0]   sh_b_q, sh_b_d, sh_c_q, sh_c_d, sh_t_q, sh_t_d;
  logic [11:0]   batt_q, curr_q, torq_q;
  logic          rdy_d, err_d, rdy_q, err_q;
  logic          start_edge, mid;

  assign start_edge  = rx_prev_q & ~rx_sync_q;
  assign mid         = (cnt_q == '0);
  assign batt_v      = batt_q;
  assign avg_curr    = curr_q;
  assign avg_torque  = torq_q;
  assign pkt_rdy     = rdy_q;
  assign pkt_err     = err_q;
  assign dbg_state_o = {uart_q, pkt_q};

  // UART: counter reloads at each sample point, first sample lands mid start bit.
  always_comb begin
    uart_d    = uart_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sr_d      = sr_q;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
    case (uart_q)
      U_IDLE: begin
        if (start_edge) begin
          uart_d = U_START;
          cnt_d  = HALF_LAST;
        end
      end
      U_START: begin
        if (!mid) cnt_d = cnt_q - CW'(1);
        else if (rx_sync_q) uart_d = U_IDLE;
        else begin
          uart_d = U_DATA;
          cnt_d  = BIT_LAST;
          bit_d  = 3'd0;
        end
      end
      U_DATA: begin
        if (!mid) cnt_d = cnt_q - CW'(1);
        else begin
          sr_d  = {rx_sync_q, sr_q[7:1]};
          cnt_d = BIT_LAST;
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) uart_d = U_STOP;
        end
      end
      U_STOP: begin
        if (!mid) cnt_d = cnt_q - CW'(1);
        else begin
          uart_d    = U_IDLE;
          byte_ok   = rx_sync_q;
          frame_err = ~rx_sync_q;
        end
      end
      default: uart_d = U_IDLE;
    endcase
  end

  // Inter-byte timeout only runs while a packet is open and the line is between bytes.
  always_comb begin
    to_cnt_d = to_cnt_q;
    to_fire  = 1'b0;
    if (pkt_q == P_HDR1 || byte_rdy_q) to_cnt_d = '0;
    else if (uart_q == U_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        to_fire  = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_comb begin
    pkt_d  = pkt_q;
    sh_b_d = sh_b_q;
    sh_c_d = sh_c_q;
    sh_t_d = sh_t_q;
    rdy_d  = 1'b0;
    err_d  = 1'b0;
    if (frame_err || to_fire) begin
      err_d = 1'b1;
      pkt_d = P_HDR1;
    end else if (byte_rdy_q) begin
      case (pkt_q)
        P_HDR1: if (sr_q == 8'hAA) pkt_d = P_HDR2;
        P_HDR2: begin
          if (sr_q == 8'h55)      pkt_d = P_BH;
          else if (sr_q != 8'hAA) pkt_d = P_HDR1;
        end
        P_BH, P_CH, P_TH: begin
          if (sr_q[7:4] != 4'd0) begin
            err_d = 1'b1;
            pkt_d = P_HDR1;
          end else begin
            if (pkt_q == P_BH) sh_b_d[11:8] = sr_q[3:0];
            if (pkt_q == P_CH) sh_c_d[11:8] = sr_q[3:0];
            if (pkt_q == P_TH) sh_t_d[11:8] = sr_q[3:0];
            pkt_d = pkt_state_e'(pkt_q + 3'd1);
          end
        end
        P_BL: begin sh_b_d[7:0] = sr_q; pkt_d = P_CH; end
        P_CL: begin sh_c_d[7:0] = sr_q; pkt_d = P_TH; end
        P_TL: begin
          sh_t_d[7:0] = sr_q;
          rdy_d       = 1'b1;
          pkt_d       = P_HDR1;
        end
        default: pkt_d = P_HDR1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      uart_q     <= U_IDLE;
      pkt_q      <= P_HDR1;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      sr_q       <= 8'd0;
      byte_rdy_q <= 1'b0;
      to_cnt_q   <= '0;
      sh_b_q     <= 12'd0;
      sh_c_q     <= 12'd0;
      sh_t_q     <= 12'd0;
      batt_q     <= 12'd0;
      curr_q     <= 12'd0;
      torq_q     <= 12'd0;
      rdy_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      uart_q     <= uart_d;
      pkt_q      <= pkt_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      sr_q       <= sr_d;
      byte_rdy_q <= byte_ok;
      to_cnt_q   <= to_cnt_d;
      sh_b_q     <= sh_b_d;
      sh_c_q     <= sh_c_d;
      sh_t_q     <= sh_t_d;
      rdy_q      <= rdy_d;
      err_q      <= err_d;
      if (rdy_d) begin
        batt_q <= sh_b_d;
        curr_q <= sh_c_d;
        torq_q <= sh_t_d;
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rx.sv
// Bench for telemetry_rx: directed scenarios plus random packet traffic scored
// against a byte-queue packet model.
module tb_telemetry_rx;
  localparam int BD = 16;
  localparam int TO_BITS = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt_v, avg_curr, avg_torque;
  logic        pkt_rdy, pkt_err;
  logic [4:0]  dbg_state;

  telemetry_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TO_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX),
    .batt_v(batt_v), .avg_curr(avg_curr), .avg_torque(avg_torque),
    .pkt_rdy(pkt_rdy), .pkt_err(pkt_err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: bytes of the packet being assembled, events as {err, batt, curr, torque}
  logic [7:0]  pq[$];
  logic [36:0] exp_q[$];
  logic [11:0] last_b = 12'd0, last_c = 12'd0, last_t = 12'd0;

  function automatic void model_err();
    exp_q.push_back({1'b1, last_b, last_c, last_t});
    pq.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit stop_ok);
    int n;
    n = pq.size();
    if (!stop_ok) begin
      model_err();
      return;
    end
    if (n == 0) begin
      if (b == 8'hAA) pq.push_back(b);
    end else if (n == 1) begin
      if (b == 8'h55) pq.push_back(b);
      else if (b != 8'hAA) pq.delete();
    end else if (n % 2 == 0) begin
      if (b[7:4] != 4'd0) model_err();
      else pq.push_back(b);
    end else begin
      pq.push_back(b);
      if (pq.size() == 8) begin
        last_b = {pq[2][3:0], pq[3]};
        last_c = {pq[4][3:0], pq[5]};
        last_t = {pq[6][3:0], pq[7]};
        exp_q.push_back({1'b0, last_b, last_c, last_t});
        pq.delete();
      end
    end
  endfunction

  function automatic void model_idle(input int bits);
    if (bits >= TO_BITS && pq.size() > 0) model_err();
  endfunction

  function automatic void model_reset();
    pq.delete();
    exp_q.delete();
    last_b = 12'd0;
    last_c = 12'd0;
    last_t = 12'd0;
  endfunction

  // scoreboard monitor
  logic [36:0] ev;
  always @(negedge clk) begin
    if (rst_n && (pkt_rdy || pkt_err)) begin
      check("rdy_err_excl", {63'd0, pkt_rdy & pkt_err}, 64'd0);
      if (exp_q.size() == 0) check("evt_expected", 64'(exp_q.size()), 64'd1);
      else begin
        ev = exp_q.pop_front();
        check("evt_kind", {63'd0, pkt_err}, {63'd0, ev[36]});
        check("evt_batt_v", {52'd0, batt_v}, {52'd0, ev[35:24]});
        check("evt_avg_curr", {52'd0, avg_curr}, {52'd0, ev[23:12]});
        check("evt_avg_torque", {52'd0, avg_torque}, {52'd0, ev[11:0]});
      end
    end
  end

  // driver tasks (all driving happens on negedges)
  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input bit modeled);
    if (modeled) model_byte(b, stop_ok);
    RX = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_ok;
    repeat (BD) @(negedge clk);
    if (!stop_ok) begin
      RX = 1'b1;
      repeat (2 * BD) @(negedge clk);
    end
  endtask

  task automatic idle_bits(input int bits);
    model_idle(bits);
    RX = 1'b1;
    repeat (bits * BD) @(negedge clk);
  endtask

  task automatic send_packet(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t,
                             input int gap_max);
    logic [7:0] pk[8];
    pk = '{8'hAA, 8'h55, {4'd0, b[11:8]}, b[7:0], {4'd0, c[11:8]}, c[7:0],
           {4'd0, t[11:8]}, t[7:0]};
    for (int i = 0; i < 8; i++) begin
      send_byte(pk[i], 1'b1, 1'b1);
      if (gap_max > 0) idle_bits($urandom_range(0, gap_max));
    end
  endtask

  task automatic check_outputs(input string tag, input logic [11:0] b, input logic [11:0] c,
                               input logic [11:0] t);
    check({tag, "_batt_v"}, {52'd0, batt_v}, {52'd0, b});
    check({tag, "_avg_curr"}, {52'd0, avg_curr}, {52'd0, c});
    check({tag, "_avg_torque"}, {52'd0, avg_torque}, {52'd0, t});
  endtask

  int lat;
  bit got;

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    repeat (5) @(negedge clk);
    check_outputs("reset", 12'h000, 12'h000, 12'h000);
    check("reset_pkt_rdy", {63'd0, pkt_rdy}, 64'd0);
    check("reset_pkt_err", {63'd0, pkt_err}, 64'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // valid packet
    send_packet(12'hA98, 12'h123, 12'h7FF, 0);
    idle_bits(3);
    check_outputs("valid", 12'hA98, 12'h123, 12'h7FF);

    // header resync
    foreach (pq[i]) pq[i] = pq[i];
    send_byte(8'h13, 1'b1, 1'b1);
    send_byte(8'hAA, 1'b1, 1'b1);
    send_packet(12'h010, 12'h020, 12'h030, 0);
    idle_bits(3);
    check_outputs("resync", 12'h010, 12'h020, 12'h030);

    // framing error on byte 5, then a clean packet
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    send_byte(8'h98, 1'b1, 1'b1);
    send_byte(8'h01, 1'b0, 1'b1);
    send_byte(8'h23, 1'b1, 1'b1);
    send_byte(8'h07, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    idle_bits(3);
    check_outputs("frame_hold", 12'h010, 12'h020, 12'h030);
    send_packet(12'h456, 12'h789, 12'hABC, 1);
    idle_bits(3);
    check_outputs("frame_recover", 12'h456, 12'h789, 12'hABC);

    // bad high nibble on byte 3
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'h1A, 1'b1, 1'b1);
    send_byte(8'h98, 1'b1, 1'b1);
    send_byte(8'h01, 1'b1, 1'b1);
    send_byte(8'h23, 1'b1, 1'b1);
    send_byte(8'h07, 1'b1, 1'b1);
    send_byte(8'hFF, 1'b1, 1'b1);
    idle_bits(3);
    check_outputs("nibble_hold", 12'h456, 12'h789, 12'hABC);

    // false start glitch
    RX = 1'b0;
    repeat (4) @(negedge clk);
    idle_bits(3);

    // timeout after byte 3
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    model_idle(25);
    RX = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 1; i <= 25 * BD; i++) begin
      @(negedge clk);
      if (pkt_err && !got) begin
        got = 1'b1;
        lat = i;
      end
    end
    check("timeout_latency", 64'((lat >= 312 && lat <= 322) ? 316 : lat), 64'd316);

    // reset during byte 6
    send_byte(8'hAA, 1'b1, 1'b1);
    send_byte(8'h55, 1'b1, 1'b1);
    send_byte(8'h0A, 1'b1, 1'b1);
    send_byte(8'h98, 1'b1, 1'b1);
    send_byte(8'h01, 1'b1, 1'b1);
    fork
      send_byte(8'h23, 1'b1, 1'b1);
      begin
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        model_reset();
      end
    join
    send_byte(8'h07, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    check_outputs("midreset", 12'h000, 12'h000, 12'h000);
    rst_n = 1'b1;
    idle_bits(2);
    send_packet(12'hA98, 12'h123, 12'h7FF, 0);
    idle_bits(3);
    check_outputs("post_reset", 12'hA98, 12'h123, 12'h7FF);

    // random traffic
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0, 1: send_packet(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                          12'($urandom_range(0, 4095)), $urandom_range(0, 2));
        2: begin
          int bad;
          bad = 2 * $urandom_range(1, 3);
          for (int i = 0; i < 8; i++) begin
            logic [7:0] b;
            if (i == 0) b = 8'hAA;
            else if (i == 1) b = 8'h55;
            else if (i == bad) b = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            else if (i % 2 == 0) b = {4'd0, 4'($urandom_range(0, 15))};
            else b = 8'($urandom_range(0, 255));
            send_byte(b, 1'b1, 1'b1);
          end
        end
        default: begin
          int nb;
          nb = $urandom_range(1, 3);
          for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        end
      endcase
      if ($urandom_range(0, 3) == 0) idle_bits(25);
      else idle_bits($urandom_range(0, 2));
    end

    idle_bits(4);
    check("events_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
